// File: rtl/thread_scheduler_if.sv
// Dispatcher/LSU-facing signal bundle for the per-core thread scheduler.
interface thread_scheduler_if #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned ID_WIDTH    = 8
);
    logic                            core_start;
    logic [ID_WIDTH-1:0]             core_block_id;
    logic [ID_WIDTH-1:0]             core_thread_count;
    logic [2*NUM_THREADS-1:0]        lsu_state;
    logic                            decoded_ret;
    logic [2:0]                      core_state;
    logic                            core_done;
    logic                            core_error;
    logic [ID_WIDTH-1:0]             block_id;
    logic [ID_WIDTH-1:0]             threads_per_block;
    logic [NUM_THREADS*ID_WIDTH-1:0] thread_id;
    logic [NUM_THREADS-1:0]          thread_mask;
    logic [15:0]                     instr_count;

    // Driver side: dispatcher, decoder and LSUs.
    modport master (
        output core_start, core_block_id, core_thread_count, lsu_state, decoded_ret,
        input  core_state, core_done, core_error, block_id, threads_per_block,
               thread_id, thread_mask, instr_count
    );

    // Scheduler side.
    modport slave (
        input  core_start, core_block_id, core_thread_count, lsu_state, decoded_ret,
        output core_state, core_done, core_error, block_id, threads_per_block,
               thread_id, thread_mask, instr_count
    );
endinterface

// File: rtl/thread_scheduler.sv
// Per-core thread scheduler: sequences the fetch/decode/request/wait/execute/update
// pipeline for one block of threads, with an LSU stall timeout.
module thread_scheduler #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned STALL_LIMIT = 255,
    parameter int unsigned STALL_WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    thread_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                          state;
    logic                            done_q;
    logic                            error_q;
    logic [ID_WIDTH-1:0]             block_id_q;
    logic [ID_WIDTH-1:0]             tpb_q;
    logic [NUM_THREADS*ID_WIDTH-1:0] tid_q;
    logic [NUM_THREADS-1:0]          mask_q;
    logic [15:0]                     icnt_q;
    logic [STALL_WIDTH-1:0]          stall_q;

    logic [NUM_THREADS-1:0]          start_mask_c;
    logic [NUM_THREADS*ID_WIDTH-1:0] start_tid_c;
    logic                            lsu_ready_c;

    // Active mask and thread IDs for a block being accepted; ready when no active thread is in flight.
    always_comb begin
        start_mask_c = '0;
        start_tid_c  = '0;
        lsu_ready_c  = 1'b1;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            start_mask_c[i] = (32'(i) < 32'(bus.core_thread_count));
            start_tid_c[i*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(i);
            // 01 (requesting) and 10 (waiting) are the only in-flight encodings
            if (mask_q[i] && (bus.lsu_state[2*i] ^ bus.lsu_state[2*i+1]))
                lsu_ready_c = 1'b0;
        end
    end

    // Pipeline state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            block_id_q <= '0;
            tpb_q      <= '0;
            tid_q      <= '0;
            mask_q     <= '0;
            icnt_q     <= '0;
            stall_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.core_start) begin
                        block_id_q <= bus.core_block_id;
                        tpb_q      <= bus.core_thread_count;
                        tid_q      <= start_tid_c;
                        mask_q     <= start_mask_c;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        icnt_q     <= '0;
                        stall_q    <= '0;
                        // an empty block finishes without fetching anything
                        state      <= (bus.core_thread_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH:   state <= S_DECODE;
                S_DECODE:  state <= S_REQUEST;
                S_REQUEST: begin
                    stall_q <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // a ready LSU takes priority over the timeout in the same cycle
                    if (lsu_ready_c) begin
                        state <= S_EXECUTE;
                    end else if (stall_q == STALL_WIDTH'(STALL_LIMIT)) begin
                        error_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        stall_q <= stall_q + STALL_WIDTH'(1);
                    end
                end
                S_EXECUTE: state <= S_UPDATE;
                S_UPDATE: begin
                    if (icnt_q != 16'hFFFF)
                        icnt_q <= icnt_q + 16'd1;
                    state <= bus.decoded_ret ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_state        = state;
    assign bus.core_done         = done_q;
    assign bus.core_error        = error_q;
    assign bus.block_id          = block_id_q;
    assign bus.threads_per_block = tpb_q;
    assign bus.thread_id         = tid_q;
    assign bus.thread_mask       = mask_q;
    assign bus.instr_count       = icnt_q;
endmodule

// File: tb/tb_thread_scheduler.sv
// Randomized bench for thread_scheduler: a block-level plan is expanded into an
// expected per-cycle trace, the plan drives the inputs, and every cycle is compared.
module tb_thread_scheduler;
    localparam int unsigned NT   = 4;
    localparam int unsigned IW   = 8;
    localparam int unsigned SL   = 4;
    localparam int unsigned SW   = 8;
    localparam int          MAXC = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    thread_scheduler_if #(.NUM_THREADS(NT), .ID_WIDTH(IW)) bus ();
    thread_scheduler #(.NUM_THREADS(NT), .ID_WIDTH(IW), .STALL_LIMIT(SL), .STALL_WIDTH(SW))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    // expected outputs per cycle
    int q_state[$], q_done[$], q_err[$], q_icnt[$], q_mask[$], q_bid[$], q_tpb[$], q_tidv[$];
    // planned inputs per cycle
    int q_start[$], q_bin[$], q_cin[$], q_lsu[$], q_ret[$];
    // observed DUT values, for literal spot checks
    int obs_state[MAXC], obs_done[MAXC], obs_err[MAXC], obs_icnt[MAXC], obs_mask[MAXC];

    // model of the visible block status
    int m_done = 0, m_err = 0, m_icnt = 0, m_mask = 0, m_bid = 0, m_tpb = 0, m_tidv = 0;

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cycle=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    function automatic int mask_of(input int cnt);
        if (cnt >= int'(NT)) return (1 << NT) - 1;
        return (1 << cnt) - 1;
    endfunction

    // every active thread idle or done; inactive threads optionally parked at 01
    function automatic int ready_lsu(input int mask, input bit park);
        logic [7:0] v;
        v = 8'($urandom);
        for (int i = 0; i < int'(NT); i++) begin
            if (mask[i]) v[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            else if (park) v[2*i +: 2] = 2'b01;
        end
        return int'(v);
    endfunction

    // at least one active thread still requesting or waiting
    function automatic int stall_lsu(input int mask, input bit park);
        logic [7:0] v;
        int i;
        v = 8'(ready_lsu(mask, park));
        i = $urandom_range(0, NT - 1);
        while (!mask[i]) i = $urandom_range(0, NT - 1);
        v[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        return int'(v);
    endfunction

    task automatic push(input int st, input int start, input int bin, input int cin,
                        input int lsu, input int ret);
        q_state.push_back(st);   q_done.push_back(m_done); q_err.push_back(m_err);
        q_icnt.push_back(m_icnt); q_mask.push_back(m_mask); q_bid.push_back(m_bid);
        q_tpb.push_back(m_tpb);  q_tidv.push_back(m_tidv);
        q_start.push_back(start); q_bin.push_back(bin); q_cin.push_back(cin);
        q_lsu.push_back(lsu);    q_ret.push_back(ret);
    endtask

    // a cycle whose inputs should not matter (start noise unless suppressed)
    task automatic push_noise(input int st, input bit force_start);
        int s;
        s = (force_start || $urandom_range(0, 3) == 0) ? 1 : 0;
        push(st, s, $urandom_range(0, 255), $urandom_range(0, 6), $urandom_range(0, 255),
             $urandom_range(0, 1));
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++)
            push(0, 0, $urandom_range(0, 255), $urandom_range(0, 6), $urandom_range(0, 255),
                 $urandom_range(0, 1));
    endtask

    // mode 0: random stalls (may time out), 1: first instruction times out, 2: no stalls
    task automatic plan_block(input int bid, input int cnt, input int ninstr, input int mode,
                              input bit park, input bit noisy, output int t0);
        int mask, s;
        t0 = q_state.size();
        mask = mask_of(cnt);
        push(0, 1, bid, cnt, $urandom_range(0, 255), $urandom_range(0, 1));
        m_done = 0; m_err = 0; m_icnt = 0; m_bid = bid; m_tpb = cnt; m_mask = mask; m_tidv = 1;
        if (cnt == 0) begin
            push_noise(7, 1'b0);
            m_done = 1;
            return;
        end
        for (int k = 0; k < ninstr; k++) begin
            push_noise(1, 1'b0);
            push_noise(2, noisy);
            push_noise(3, 1'b0);
            s = (mode == 0) ? $urandom_range(0, SL + 1) : (mode == 1) ? SL + 1 : 0;
            if (s > int'(SL)) begin
                // counter runs 0..SL while stalled; the cycle it sits at SL times out
                for (int j = 0; j <= int'(SL); j++)
                    push(4, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 6),
                         stall_lsu(mask, park), $urandom_range(0, 1));
                m_err = 1;
                push_noise(7, 1'b0);
                m_done = 1;
                return;
            end
            for (int j = 0; j < s; j++)
                push(4, 0, 0, 0, stall_lsu(mask, park), $urandom_range(0, 1));
            push(4, $urandom_range(0, 1), 0, 0, ready_lsu(mask, park), $urandom_range(0, 1));
            push_noise(5, noisy);
            push(6, 0, 0, 0, $urandom_range(0, 255), (k == ninstr - 1) ? 1 : 0);
            if (m_icnt < 65535) m_icnt++;
        end
        push_noise(7, 1'b0);
        m_done = 1;
    endtask

    task automatic drive(input int t);
        bus.core_start        = q_start[t][0];
        bus.core_block_id     = 8'(q_bin[t]);
        bus.core_thread_count = 8'(q_cin[t]);
        bus.lsu_state         = 8'(q_lsu[t]);
        bus.decoded_ret       = q_ret[t][0];
    endtask

    task automatic compare(input int t);
        logic [31:0] tid_exp;
        tid_exp = (q_tidv[t] != 0) ? 32'h03020100 : 32'h0;
        obs_state[t] = int'(bus.core_state);  obs_done[t] = int'(bus.core_done);
        obs_err[t]   = int'(bus.core_error);  obs_icnt[t] = int'(bus.instr_count);
        obs_mask[t]  = int'(bus.thread_mask);
        chk("state",     t, 32'(bus.core_state),        32'(q_state[t]));
        chk("done",      t, 32'(bus.core_done),         32'(q_done[t]));
        chk("error",     t, 32'(bus.core_error),        32'(q_err[t]));
        chk("icnt",      t, 32'(bus.instr_count),       32'(q_icnt[t]));
        chk("mask",      t, 32'(bus.thread_mask),       32'(q_mask[t]));
        chk("block_id",  t, 32'(bus.block_id),          32'(q_bid[t]));
        chk("tpb",       t, 32'(bus.threads_per_block), 32'(q_tpb[t]));
        chk("thread_id", t, 32'(bus.thread_id),         tid_exp);
    endtask

    initial begin
        int t_a, t_b, t_c, t_d, t_e, t_x, n;
        bit found;

        bus.core_start = 1'b0; bus.core_block_id = '0; bus.core_thread_count = '0;
        bus.lsu_state = '0; bus.decoded_ret = 1'b0;

        // directed blocks first, then random ones
        push_idle(1);
        plan_block(8'h05, 4, 1, 2, 1'b0, 1'b0, t_a);   // single instruction, RET
        push_idle(1);
        plan_block(8'h21, 2, 1, 2, 1'b1, 1'b0, t_b);   // two threads, idle threads parked at 01
        push_idle(1);
        plan_block(8'h33, 4, 2, 1, 1'b0, 1'b0, t_c);   // timeout on first instruction
        plan_block(8'h44, 0, 1, 2, 1'b0, 1'b0, t_d);   // empty block
        push_idle(2);
        plan_block(8'h55, 3, 4, 2, 1'b0, 1'b1, t_e);   // four instructions, start pulses mid-block
        push_idle(1);
        for (int b = 0; b < 60; b++) begin
            plan_block($urandom_range(0, 255), $urandom_range(0, 6), $urandom_range(1, 4),
                       0, 1'b0, 1'b0, t_x);
            push_idle($urandom_range(0, 2));
        end
        push_idle(2);
        n = q_state.size();
        if (n > MAXC) n = MAXC;

        // asynchronous reset, checked before any clock edge
        #1 reset = 1'b0;
        #1;
        chk("por_state", 0, 32'(bus.core_state), 32'h0);
        chk("por_outs",  0, {bus.core_done, bus.core_error, 14'h0, bus.instr_count}, 32'h0);
        chk("por_ids",   0, {bus.block_id, bus.threads_per_block, 12'h0, bus.thread_mask}, 32'h0);
        chk("por_tid",   0, 32'(bus.thread_id), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            compare(t);
            drive(t);
        end

        // hand-computed pins on the observed trace
        for (int k = 0; k < 8; k++)
            chk("seq_basic", t_a + 1 + k, 32'(obs_state[t_a + 1 + k]), 32'((k + 1) % 8));
        chk("basic_done", t_a + 8, 32'(obs_done[t_a + 8]), 32'd1);
        chk("basic_icnt", t_a + 8, 32'(obs_icnt[t_a + 8]), 32'd1);
        chk("basic_mask", t_a + 1, 32'(obs_mask[t_a + 1]), 32'hF);
        chk("two_wait",   t_b + 4, 32'(obs_state[t_b + 4]), 32'd4);
        chk("two_exec",   t_b + 5, 32'(obs_state[t_b + 5]), 32'd5);
        chk("two_mask",   t_b + 5, 32'(obs_mask[t_b + 5]), 32'h3);
        for (int k = 0; k <= int'(SL); k++)
            chk("to_wait", t_c + 4 + k, 32'(obs_state[t_c + 4 + k]), 32'd4);
        chk("to_done",    t_c + 9,  32'(obs_state[t_c + 9]), 32'd7);
        chk("to_err",     t_c + 9,  32'(obs_err[t_c + 9]), 32'd1);
        chk("to_cdone",   t_c + 10, 32'(obs_done[t_c + 10]), 32'd1);
        chk("to_icnt",    t_c + 10, 32'(obs_icnt[t_c + 10]), 32'd0);
        chk("empty_seq",  t_d + 1,  32'(obs_state[t_d + 1]), 32'd7);
        chk("empty_idle", t_d + 2,  32'(obs_state[t_d + 2]), 32'd0);
        chk("empty_done", t_d + 2,  32'(obs_done[t_d + 2]), 32'd1);
        chk("lat_fetch",  t_e + 7,  32'(obs_state[t_e + 7]), 32'd1);
        chk("multi_done", t_e + 25, 32'(obs_state[t_e + 25]), 32'd7);
        chk("multi_icnt", t_e + 26, 32'(obs_icnt[t_e + 26]), 32'd4);

        // reset asserted while in EXECUTE
        bus.core_start = 1'b1; bus.core_block_id = 8'h09; bus.core_thread_count = 8'd4;
        bus.lsu_state = 8'hFF; bus.decoded_ret = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            bus.core_start = 1'b0;
            if (bus.core_state == 3'd5) found = 1'b1;
        end
        chk("reach_exec", 0, 32'(found), 32'd1);
        if (found) begin
            #2 reset = 1'b0;
            #1;
            chk("ar_state", 0, 32'(bus.core_state), 32'h0);
            chk("ar_outs",  0, {bus.core_done, bus.core_error, 14'h0, bus.instr_count}, 32'h0);
            chk("ar_ids",   0, {bus.block_id, bus.threads_per_block, 12'h0, bus.thread_mask}, 32'h0);
            chk("ar_tid",   0, 32'(bus.thread_id), 32'h0);
            @(negedge clk);
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("ar_idle", k, 32'(bus.core_state), 32'h0);
                chk("ar_nodone", k, 32'(bus.core_done), 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  NUM_THREADS, 4, threads per core (1..64)
  ID_WIDTH, 8, width of block/thread ID and thread count
  STALL_LIMIT, 255, maximum WAIT cycles before timeout (1..2^STALL_WIDTH-1)
  STALL_WIDTH, 8, stall counter width
REQ-002 SHALL have ports (name, direction, width, meaning), one per line, clock and reset first:
  clk  input  1  single clock, all state on rising edge
  reset  input  1  asynchronous, active-low reset
  core_start  input  1  dispatcher start pulse, sampled only in IDLE
  core_block_id  input  ID_WIDTH  block ID
  core_thread_count  input  ID_WIDTH  threads in block
  lsu_state  input  2*NUM_THREADS  per-thread LSU state, thread i at [2i+1:2i]; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
  decoded_ret  input  1  RET decoded for the current instruction
  core_state  output  3  pipeline state
  core_done  output  1  block finished; level
  core_error  output  1  block aborted on LSU timeout; level
  block_id  output  ID_WIDTH  latched block ID
  threads_per_block  output  ID_WIDTH  latched raw thread count
  thread_id  output  NUM_THREADS*ID_WIDTH  thread i ID at [(i+1)*ID_WIDTH-1 : i*ID_WIDTH]
  thread_mask  output  NUM_THREADS  active-thread mask
  instr_count  output  16  instructions retired in the current block

Function
REQ-003 SHALL encode states IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111; core_state SHALL equal the current state.
REQ-004 In IDLE with core_start=1: SHALL latch block_id and threads_per_block, set thread_id[i]=i, compute thread_mask, clear core_done, core_error, instr_count and the stall counter, then go to FETCH; core_start outside IDLE SHALL be ignored.
REQ-005 thread_mask bit i SHALL be 1 iff i < core_thread_count; a count >= NUM_THREADS SHALL give all ones.
REQ-006 core_start with core_thread_count=0 SHALL go from IDLE directly to DONE with no FETCH.
REQ-007 FETCH->DECODE->REQUEST->WAIT SHALL each take exactly one cycle.
REQ-008 WAIT SHALL exit to EXECUTE in the cycle every active thread's lsu_state is 00 or 11; inactive threads' lsu_state SHALL be ignored.
REQ-009 While WAIT's exit condition is false, the stall counter SHALL increment each cycle; when it equals STALL_LIMIT and the condition is still false, the scheduler SHALL set core_error=1 and go to DONE.
REQ-010 Exit-condition true in the same cycle the counter reaches STALL_LIMIT: EXECUTE SHALL win and no error SHALL be raised.
REQ-011 The stall counter SHALL clear on every entry to WAIT.
REQ-012 EXECUTE->UPDATE SHALL take one cycle.
REQ-013 In UPDATE, instr_count SHALL increment by 1, saturating at 16'hFFFF; decoded_ret=1 SHALL go to DONE, otherwise to FETCH.
REQ-014 DONE SHALL set core_done=1 (and keep core_error as set) and go to IDLE the next cycle.
REQ-015 core_done and core_error SHALL hold in IDLE until the next accepted core_start.
REQ-016 Minimum non-stalled instruction latency SHALL be 6 cycles, FETCH to FETCH.

Reset
REQ-017 reset=0 SHALL immediately, without waiting for clk, force: core_state=IDLE, core_done=0, core_error=0, block_id=0, threads_per_block=0, thread_id=0, thread_mask=0, instr_count=0, stall counter=0.
REQ-018 Reset asserted mid-block SHALL abandon the block with no core_done pulse; the first rising edge after deassertion SHALL evaluate IDLE.

Verification
REQ-019 Start, count=4, block_id=8'h05, all LSU=11, decoded_ret=1 on the 1st UPDATE -> states 1,2,3,4,5,6,7,0; core_done=1, instr_count=1, thread_mask=4'b1111.
REQ-020 Count=2, lsu_state threads 2/3 held at 01, threads 0/1 at 11 -> WAIT exits in 1 cycle, thread_mask=4'b0011.
REQ-021 STALL_LIMIT=4, thread 0 held at 10 -> core_error=1 and core_done=1 after exactly 4 stall cycles, instr_count=0.
REQ-022 Count=0 -> IDLE, DONE, IDLE; core_done=1; no FETCH visited.
REQ-023 3 instructions with no RET, RET on the 4th; core_start pulsed in the middle -> instr_count=4, core_start ignored.
REQ-024 reset pulsed low asynchronously in EXECUTE -> all outputs zero before the next clk edge; core_done stays 0.
